fetch_issue_queue: RTL and testbench

- Transmit side of the decode-stage input interface: buffers fetched instruction words and issues them one per cycle to the format-specific decoders.
- Issued fields: enable, instruction, primary opcode, address, 64-bit mode, PID, TID, major ID.
- Assigns the monotonically increasing major ID at issue time.
- Honours the decoders' stall and a pipeline flush.

---
 rtl/fetch_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_fetch_issue_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: buffers fetched instruction words in a small FIFO and
// issues them one per cycle to the decoders, stamping each issued word with
// a monotonically increasing major ID. Honours decoder stall and pipeline flush.
module fetch_issue_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int PrimOpcodeSize          = 6,
  parameter int queueDepth              = 4,
  parameter int queueIndexWidth         = 2
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o,
  output logic [queueIndexWidth:0]           occupancy_o
);

  localparam logic [queueIndexWidth:0]           FullCount = (queueIndexWidth+1)'(queueDepth);
  localparam logic [queueIndexWidth:0]           CountOne  = (queueIndexWidth+1)'(1);
  localparam logic [queueIndexWidth-1:0]         PtrOne    = queueIndexWidth'(1);
  localparam logic [instructionCounterWidth-1:0] MajOne    = instructionCounterWidth'(1);

  // Queue storage; contents are don't-care after reset, so no reset is needed.
  logic [instructionWidth-1:0] instrMem_q [queueDepth];
  logic [addressWidth-1:0]     addrMem_q  [queueDepth];
  logic                        modeMem_q  [queueDepth];
  logic [PidSize-1:0]          pidMem_q   [queueDepth];
  logic [TidSize-1:0]          tidMem_q   [queueDepth];

  logic [queueIndexWidth-1:0]         wrPtr_q, wrPtr_d;
  logic [queueIndexWidth-1:0]         rdPtr_q, rdPtr_d;
  logic [queueIndexWidth:0]           count_q, count_d;
  logic [instructionCounterWidth-1:0] majCnt_q, majCnt_d;

  logic                               enable_q, enable_d;
  logic [instructionWidth-1:0]        instr_q, instr_d;
  logic [PrimOpcodeSize-1:0]          opcode_q, opcode_d;
  logic [addressWidth-1:0]            addr_q, addr_d;
  logic                               mode_q, mode_d;
  logic [PidSize-1:0]                 pid_q, pid_d;
  logic [TidSize-1:0]                 tid_q, tid_d;
  logic [instructionCounterWidth-1:0] majOut_q, majOut_d;

  logic notFull;
  logic doPush;
  logic doPop;

  // Ready comes from the registered count only, so a full queue refuses a
  // push even when the same edge pops.
  assign notFull = (count_q != FullCount);

  // Next-state logic: flush overrides everything, stall freezes the outputs,
  // otherwise the head entry moves into the output registers.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    majCnt_d = majCnt_q;
    enable_d = enable_q;
    instr_d  = instr_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    pid_d    = pid_q;
    tid_d    = tid_q;
    majOut_d = majOut_q;
    doPush   = fetchValid_i && notFull && !flush_i;
    doPop    = !stall_i && (count_q != '0) && !flush_i;

    if (flush_i) begin
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      count_d  = '0;
      enable_d = 1'b0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + PtrOne;
      end
      if (doPop) begin
        rdPtr_d  = rdPtr_q + PtrOne;
        enable_d = 1'b1;
        instr_d  = instrMem_q[rdPtr_q];
        opcode_d = instrMem_q[rdPtr_q][instructionWidth-1 -: PrimOpcodeSize];
        addr_d   = addrMem_q[rdPtr_q];
        mode_d   = modeMem_q[rdPtr_q];
        pid_d    = pidMem_q[rdPtr_q];
        tid_d    = tidMem_q[rdPtr_q];
        majOut_d = majCnt_q;
        majCnt_d = majCnt_q + MajOne;
      end else if (!stall_i) begin
        enable_d = 1'b0;
      end
      if (doPush && !doPop) begin
        count_d = count_q + CountOne;
      end else if (!doPush && doPop) begin
        count_d = count_q - CountOne;
      end
    end
  end

  // Write accepted fetch words into the slot at the write pointer.
  always_ff @(posedge clock_i) begin
    if (doPush) begin
      instrMem_q[wrPtr_q] <= instruction_i;
      addrMem_q[wrPtr_q]  <= instructionAddress_i;
      modeMem_q[wrPtr_q]  <= is64Bit_i;
      pidMem_q[wrPtr_q]   <= instructionPid_i;
      tidMem_q[wrPtr_q]   <= instructionTid_i;
    end
  end

  // Pointer, count, ID counter and output registers; reset clears them at once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      majCnt_q <= '0;
      enable_q <= 1'b0;
      instr_q  <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      mode_q   <= 1'b0;
      pid_q    <= '0;
      tid_q    <= '0;
      majOut_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      majCnt_q <= majCnt_d;
      enable_q <= enable_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      pid_q    <= pid_d;
      tid_q    <= tid_d;
      majOut_q <= majOut_d;
    end
  end

  assign fetchReady_o         = notFull;
  assign occupancy_o          = count_q;
  assign enable_o             = enable_q;
  assign instruction_o        = instr_q;
  assign instructionOpcode_o  = opcode_q;
  assign instructionAddress_o = addr_q;
  assign is64Bit_o            = mode_q;
  assign instructionPid_o     = pid_q;
  assign instructionTid_o     = tid_q;
  assign instructionMajId_o   = majOut_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb_fetch_issue_queue: scoreboard-driven bench for the fetch issue queue.
// Expected entries are queued when a push is driven and compared, together
// with a bench-side major ID counter, whenever the queue issues.
module tb_fetch_issue_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        mode;
    logic [19:0] pid;
    logic [15:0] tid;
  } entry_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] instrIn;
  logic [63:0] addrIn;
  logic        modeIn;
  logic [19:0] pidIn;
  logic [15:0] tidIn;
  logic        stall;
  logic        enable;
  logic [31:0] instrOut;
  logic [5:0]  opcodeOut;
  logic [63:0] addrOut;
  logic        modeOut;
  logic [19:0] pidOut;
  logic [15:0] tidOut;
  logic [63:0] majIdOut;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  entry_t      sb[$];
  logic [63:0] expMaj = '0;
  logic        edgeStall = 1'b0;
  logic        edgeFlush = 1'b0;
  logic        edgeReset = 1'b0;
  entry_t      cur;

  fetch_issue_queue dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .flush_i              (flush),
    .fetchValid_i         (fetchValid),
    .fetchReady_o         (fetchReady),
    .instruction_i        (instrIn),
    .instructionAddress_i (addrIn),
    .is64Bit_i            (modeIn),
    .instructionPid_i     (pidIn),
    .instructionTid_i     (tidIn),
    .stall_i              (stall),
    .enable_o             (enable),
    .instruction_o        (instrOut),
    .instructionOpcode_o  (opcodeOut),
    .instructionAddress_o (addrOut),
    .is64Bit_o            (modeOut),
    .instructionPid_o     (pidOut),
    .instructionTid_o     (tidOut),
    .instructionMajId_o   (majIdOut),
    .occupancy_o          (occupancy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Remember the control inputs seen at each rising edge.
  always @(posedge clock) begin
    edgeStall = stall;
    edgeFlush = flush;
    edgeReset = reset;
  end

  // Scoreboard: every unstalled, unflushed edge that leaves enable high is a new issue.
  always @(negedge clock) begin
    if (!edgeReset && !edgeFlush && !edgeStall && enable === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL spurious_issue: got issue with majId=%0d, required no issue", majIdOut);
      end else begin
        cur = sb.pop_front();
        if (instrOut !== cur.instr || opcodeOut !== cur.instr[31:26] || addrOut !== cur.addr ||
            modeOut !== cur.mode || pidOut !== cur.pid || tidOut !== cur.tid) begin
          errors++;
          $display("[TB] FAIL issue_fields: got instr=%h op=%0d addr=%h m=%b pid=%h tid=%h, required instr=%h op=%0d addr=%h m=%b pid=%h tid=%h",
                   instrOut, opcodeOut, addrOut, modeOut, pidOut, tidOut,
                   cur.instr, cur.instr[31:26], cur.addr, cur.mode, cur.pid, cur.tid);
        end
        checks++;
        if (majIdOut !== expMaj) begin
          errors++;
          $display("[TB] FAIL issue_majId: got %0d, required %0d", majIdOut, expMaj);
        end
        expMaj = expMaj + 64'd1;
      end
    end
  end

  function automatic entry_t mkEntry(int op, int k);
    entry_t e;
    logic [5:0]  opBits;
    logic [25:0] low;
    opBits  = 6'(op);
    low     = 26'(k * 7 + 1);
    e.instr = {opBits, low};
    e.addr  = 64'h1000 + 64'(k * 4);
    e.mode  = 1'(k);
    e.pid   = 20'(k + 3);
    e.tid   = 16'(k * 5);
    return e;
  endfunction

  task automatic applyStimulus(input entry_t e, input logic valid);
    instrIn    = e.instr;
    addrIn     = e.addr;
    modeIn     = e.mode;
    pidIn      = e.pid;
    tidIn      = e.tid;
    fetchValid = valid;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    sb.delete();
    expMaj = '0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (enable !== 1'b0 || occupancy !== 3'd0 || fetchReady !== 1'b1 || majIdOut !== 64'd0 || instrOut !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got en=%b occ=%0d rdy=%b maj=%0d instr=%h, required en=0 occ=0 rdy=1 maj=0 instr=0",
               enable, occupancy, fetchReady, majIdOut, instrOut);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_issue();
    entry_t e;
    e.instr = 32'h48000001; e.addr = 64'h100; e.mode = 1'b1; e.pid = 20'd5; e.tid = 16'd3;
    applyStimulus(e, 1'b1);
    sb.push_back(e);
    tick();
    applyStimulus(e, 1'b0);
    checks++;
    if (occupancy !== 3'd1 || enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_push: got occ=%0d en=%b, required occ=1 en=0", occupancy, enable);
    end
    tick();
    checks++;
    if (enable !== 1'b1 || opcodeOut !== 6'd18 || instrOut !== 32'h48000001 || addrOut !== 64'h100 ||
        pidOut !== 20'd5 || tidOut !== 16'd3 || modeOut !== 1'b1 || majIdOut !== 64'd0) begin
      errors++;
      $display("[TB] FAIL single_issue: got en=%b op=%0d instr=%h addr=%h pid=%0d tid=%0d m=%b maj=%0d, required 1 18 48000001 100 5 3 1 0",
               enable, opcodeOut, instrOut, addrOut, pidOut, tidOut, modeOut, majIdOut);
    end
    tick();
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got en=%b, required 0", enable);
    end
  endtask

  task automatic test_fill();
    entry_t e;
    pulseReset();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = mkEntry(16 + k, 10 + k);
      applyStimulus(e, 1'b1);
      sb.push_back(e);
      tick();
    end
    checks++;
    if (occupancy !== 3'd4 || fetchReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: got occ=%0d rdy=%b, required occ=4 rdy=0", occupancy, fetchReady);
    end
    applyStimulus(mkEntry(20, 14), 1'b1);
    tick();
    checks++;
    if (occupancy !== 3'd4 || fetchReady !== 1'b0 || enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_overflow: got occ=%0d rdy=%b en=%b, required occ=4 rdy=0 en=0", occupancy, fetchReady, enable);
    end
    fetchValid = 1'b0;
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (enable !== 1'b1 || opcodeOut !== 6'(16 + k) || majIdOut !== 64'(k)) begin
        errors++;
        $display("[TB] FAIL fill_drain: got en=%b op=%0d maj=%0d, required en=1 op=%0d maj=%0d", enable, opcodeOut, majIdOut, 16 + k, k);
      end
    end
    tick();
    checks++;
    if (enable !== 1'b0 || occupancy !== 3'd0 || opcodeOut !== 6'd19 || majIdOut !== 64'd3) begin
      errors++;
      $display("[TB] FAIL fill_empty: got en=%b occ=%0d op=%0d maj=%0d, required en=0 occ=0 op=19 maj=3", enable, occupancy, opcodeOut, majIdOut);
    end
  endtask

  task automatic test_stall();
    entry_t a, b, c;
    pulseReset();
    a = mkEntry(31, 20); b = mkEntry(32, 21); c = mkEntry(33, 22);
    applyStimulus(a, 1'b1); sb.push_back(a); tick();
    applyStimulus(b, 1'b1); sb.push_back(b); tick();
    applyStimulus(c, 1'b1); sb.push_back(c); tick();
    fetchValid = 1'b0;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (enable !== 1'b1 || majIdOut !== 64'd1 || instrOut !== b.instr || addrOut !== b.addr || occupancy !== 3'd1) begin
        errors++;
        $display("[TB] FAIL stall_hold: got en=%b maj=%0d instr=%h addr=%h occ=%0d, required en=1 maj=1 instr=%h addr=%h occ=1",
                 enable, majIdOut, instrOut, addrOut, occupancy, b.instr, b.addr);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (enable !== 1'b1 || majIdOut !== 64'd2 || instrOut !== c.instr) begin
      errors++;
      $display("[TB] FAIL stall_release: got en=%b maj=%0d instr=%h, required en=1 maj=2 instr=%h", enable, majIdOut, instrOut, c.instr);
    end
    tick();
  endtask

  task automatic test_flush();
    entry_t e;
    pulseReset();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = mkEntry(40 + k, 30 + k);
      applyStimulus(e, 1'b1); sb.push_back(e); tick();
    end
    stall = 1'b0;
    for (int k = 3; k < 5; k++) begin
      e = mkEntry(40 + k, 30 + k);
      applyStimulus(e, 1'b1); sb.push_back(e); tick();
    end
    checks++;
    if (occupancy !== 3'd3 || enable !== 1'b1 || majIdOut !== 64'd1) begin
      errors++;
      $display("[TB] FAIL flush_setup: got occ=%0d en=%b maj=%0d, required occ=3 en=1 maj=1", occupancy, enable, majIdOut);
    end
    applyStimulus(mkEntry(45, 35), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetchValid = 1'b0;
    sb.delete();
    checks++;
    if (occupancy !== 3'd0 || enable !== 1'b0 || fetchReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_clear: got occ=%0d en=%b rdy=%b, required occ=0 en=0 rdy=1", occupancy, enable, fetchReady);
    end
    e = mkEntry(46, 36);
    applyStimulus(e, 1'b1); sb.push_back(e); tick();
    fetchValid = 1'b0;
    tick();
    checks++;
    if (enable !== 1'b1 || majIdOut !== 64'd2 || instrOut !== e.instr) begin
      errors++;
      $display("[TB] FAIL flush_next: got en=%b maj=%0d instr=%h, required en=1 maj=2 instr=%h", enable, majIdOut, instrOut, e.instr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    entry_t e;
    pulseReset();
    e = mkEntry(0, 50);
    applyStimulus(e, 1'b1); sb.push_back(e); tick();
    for (int k = 1; k <= 10; k++) begin
      e = mkEntry(k, 50 + k);
      applyStimulus(e, 1'b1); sb.push_back(e); tick();
      checks++;
      if (occupancy !== 3'd1 || enable !== 1'b1 || opcodeOut !== 6'(k - 1) || majIdOut !== 64'(k - 1)) begin
        errors++;
        $display("[TB] FAIL b2b_issue: got occ=%0d en=%b op=%0d maj=%0d, required occ=1 en=1 op=%0d maj=%0d",
                 occupancy, enable, opcodeOut, majIdOut, k - 1, k - 1);
      end
    end
    fetchValid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 3'd0 || opcodeOut !== 6'd10 || majIdOut !== 64'd10) begin
      errors++;
      $display("[TB] FAIL b2b_last: got occ=%0d op=%0d maj=%0d, required occ=0 op=10 maj=10", occupancy, opcodeOut, majIdOut);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    entry_t e;
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) stall = 1'b1;
      e = mkEntry(50 + k, 60 + k);
      applyStimulus(e, 1'b1); sb.push_back(e); tick();
    end
    fetchValid = 1'b0;
    checks++;
    if (occupancy !== 3'd3 || enable !== 1'b1 || majIdOut !== 64'd11) begin
      errors++;
      $display("[TB] FAIL midreset_setup: got occ=%0d en=%b maj=%0d, required occ=3 en=1 maj=11", occupancy, enable, majIdOut);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (enable !== 1'b0 || occupancy !== 3'd0 || fetchReady !== 1'b1 || majIdOut !== 64'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got en=%b occ=%0d rdy=%b maj=%0d, required en=0 occ=0 rdy=1 maj=0", enable, occupancy, fetchReady, majIdOut);
    end
    reset = 1'b0;
    sb.delete();
    expMaj = '0;
    stall = 1'b0;
    e = mkEntry(57, 70);
    applyStimulus(e, 1'b1); sb.push_back(e); tick();
    fetchValid = 1'b0;
    tick();
    checks++;
    if (enable !== 1'b1 || majIdOut !== 64'd0 || instrOut !== e.instr) begin
      errors++;
      $display("[TB] FAIL midreset_next: got en=%b maj=%0d instr=%h, required en=1 maj=0 instr=%h", enable, majIdOut, instrOut, e.instr);
    end
    tick();
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    reset = 1'b0; flush = 1'b0; stall = 1'b0; fetchValid = 1'b0;
    instrIn = '0; addrIn = '0; modeIn = 1'b0; pidIn = '0; tidIn = '0;
    test_reset();
    test_single_issue();
    test_fill();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries never issued, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
